mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage front end that sits directly upstream of the word-organised data memory (dmem) and turns pipeline load/store requests into dmem enable/read/write/address/data cycles.
- Supports LB/LBU/LH/LHU/LW/SB/SH/SW. dmem has no byte enables, so sub-word stores are done as a read-modify-write sequence.
- Checks alignment, sign/zero-extends load data, and stalls the pipeline until the access completes.

Parameters:
- NB_DATA, 32, data width; only 32 is supported.
- NB_ADDR, 32, byte-address width from the pipeline.
- ADDRWIDTH, `ADDRWIDTH from parameters.vh, word-address width driven to dmem.

Ports:
- i_clock  in  1  single clock; all state updates on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  request present; held stable by the pipeline while o_stall=1.
- i_write  in  1  1=store, 0=load.
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- i_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- i_addr  in  NB_ADDR  byte address.
- i_wdata  in  NB_DATA  store data, right-aligned.
- o_stall  out  1  freeze the pipeline.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  NB_DATA  extended load result; valid while o_done=1.
- o_misaligned  out  1  one-cycle error pulse.
- o_mem_enable, o_mem_read, o_mem_write  out  1 each  to dmem.
- o_mem_addr  out  ADDRWIDTH  word address = i_addr[ADDRWIDTH+1:2].
- o_mem_wdata  out  NB_DATA  to dmem.
- i_mem_rdata  in  NB_DATA  from dmem; sampled at the posedge that ends a read cycle, since dmem updates on the negedge.

Behaviour:
- Byte order is little-endian: byte lane k = bits 8k+7:8k, with k = i_addr[1:0].
- Reset (asynchronous): state goes to IDLE and every output is 0. o_mem_write drops immediately, so a store interrupted by reset never reaches dmem. A held request is re-accepted from IDLE after reset deasserts.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE with i_valid=1 checks alignment first. A request is misaligned if:
  - size=01 and addr[0]=1,
  - size=10 and addr[1:0]!=0, or
  - size=11.
- Misaligned request: o_misaligned=1 and o_done=1 combinationally that same cycle, o_stall=0, no dmem access, state stays IDLE.
- Aligned request in IDLE: o_stall=1 combinationally, then at the posedge:
  - load goes to LOAD,
  - SW goes to STORE,
  - SB/SH goes to RMW_RD.
  - The address, size, unsigned flag and data are registered at this edge.
- LOAD: enable=1, read=1. At the closing posedge, capture i_mem_rdata, extract the lane and extend it into the o_rdata register, then go to RESP.
- STORE: enable=1, write=1, wdata = i_wdata. Go to RESP.
- RMW_RD: enable=1, read=1. Capture the old word, go to RMW_WR.
- RMW_WR: enable=1, write=1. wdata = old word with the selected byte or halfword lane replaced by the low bits of the registered wdata. Go to RESP.
- RESP: o_done=1, o_stall=0. The pipeline advances on this edge. i_valid is ignored; go to IDLE.
- o_stall=1 in LOAD, STORE, RMW_RD and RMW_WR.
- Latency from acceptance to o_done:
  - load: 2 cycles,
  - SW: 2 cycles,
  - SB/SH: 3 cycles.
  - A back-to-back request is accepted no earlier than the cycle after RESP.
- dmem outputs are registered, with no combinational path from i_* to o_mem_*.
  - o_mem_addr holds its last value when idle.
  - enable/read/write are 0 outside the access states.
- o_rdata holds its value until the next load completes.

Test Plan:
- dmem preset with RAM[i]=i. LW at addr 0x14 (i_size=10, i_unsigned=0) -> o_stall=1 for 2 cycles; then o_done=1 and o_rdata=0x00000005.
- SB at addr 0x15 with wdata=0xFFFFFFAB -> one read then one write to word 5 with o_mem_wdata=0x0000AB05. A following LBU at 0x15 returns 0x000000AB; LB at 0x15 returns 0xFFFFFFAB.
- SH at addr 0x1A with wdata=0x00008001 -> word 6 becomes 0x80010006. LH at 0x1A returns 0xFFFF8001; LHU at 0x1A returns 0x00008001.
- LH at 0x13, LW at 0x22 and size=11 at 0x20 -> each gives an o_misaligned pulse with o_done=1 the same cycle, o_mem_enable stays 0, and dmem contents are unchanged.
- Two back-to-back requests, SW 0x12345678 to 0x08 then LW from 0x08 -> the second request is accepted the cycle after RESP and returns 0x12345678. o_stall never drops between the requests except in the RESP cycle.
- Assert i_reset during RMW_WR of SB to 0x04 -> all outputs go to 0 immediately and word 1 still reads 0x00000001. After release, the held request completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a word-organised dmem without byte enables.
// Sub-word stores are done as a read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
  parameter int NB_DATA   = 32,
  parameter int NB_ADDR   = 32,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_write,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_DATA-1:0]   i_wdata,
  output logic                 o_stall,
  output logic                 o_done,
  output logic [NB_DATA-1:0]   o_rdata,
  output logic                 o_misaligned,
  output logic                 o_mem_enable,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [ADDRWIDTH-1:0] o_mem_addr,
  output logic [NB_DATA-1:0]   o_mem_wdata,
  input  logic [NB_DATA-1:0]   i_mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t               state, next_state;
  logic                 misaligned;
  logic [1:0]           lane_q;
  logic [1:0]           size_q;
  logic                 unsigned_q;
  logic [NB_DATA-1:0]   wdata_q;
  logic [4:0]           shift;
  logic [NB_DATA-1:0]   lane_data;
  logic [NB_DATA-1:0]   load_ext;
  logic [NB_DATA-1:0]   mask;
  logic [NB_DATA-1:0]   merged;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^i_addr[NB_ADDR-1:ADDRWIDTH+2];

  always_comb begin
    misaligned = (i_size == 2'b11) ||
                 (i_size == 2'b01 && i_addr[0]) ||
                 (i_size == 2'b10 && i_addr[1:0] != 2'b00);
  end

  always_comb begin
    next_state   = state;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    o_misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (misaligned) begin
            o_misaligned = 1'b1;
            o_done       = 1'b1;
          end else begin
            o_stall = 1'b1;
            if (!i_write)              next_state = LOAD;
            else if (i_size == 2'b10)  next_state = STORE;
            else                       next_state = RMW_RD;
          end
        end
      end
      LOAD, STORE, RMW_WR: begin
        o_stall    = 1'b1;
        next_state = RESP;
      end
      RMW_RD: begin
        o_stall    = 1'b1;
        next_state = RMW_WR;
      end
      RESP: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Handshake outputs are forced low while reset is held, even with a request pending.
    if (i_reset) begin
      o_stall      = 1'b0;
      o_done       = 1'b0;
      o_misaligned = 1'b0;
    end
  end

  always_comb begin
    shift     = {lane_q, 3'b000};
    lane_data = i_mem_rdata >> shift;
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {{(NB_DATA-8){1'b0}}, lane_data[7:0]}
                                     : {{(NB_DATA-8){lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_ext = unsigned_q ? {{(NB_DATA-16){1'b0}}, lane_data[15:0]}
                                     : {{(NB_DATA-16){lane_data[15]}}, lane_data[15:0]};
      default: load_ext = i_mem_rdata;
    endcase
    if (size_q == 2'b00) mask = {{(NB_DATA-8){1'b0}}, 8'hFF} << shift;
    else                 mask = {{(NB_DATA-16){1'b0}}, 16'hFFFF} << shift;
    merged = (i_mem_rdata & ~mask) | ((wdata_q << shift) & mask);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      o_mem_enable <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_rdata      <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state        <= next_state;
      // Bus strobes are decoded from the next state so they are registered yet aligned with it.
      o_mem_enable <= (next_state == LOAD) || (next_state == STORE) ||
                      (next_state == RMW_RD) || (next_state == RMW_WR);
      o_mem_read   <= (next_state == LOAD) || (next_state == RMW_RD);
      o_mem_write  <= (next_state == STORE) || (next_state == RMW_WR);
      if (state == IDLE && next_state != IDLE) begin
        o_mem_addr <= i_addr[ADDRWIDTH+1:2];
        lane_q     <= i_addr[1:0];
        size_q     <= i_size;
        unsigned_q <= i_unsigned;
        wdata_q    <= i_wdata;
        if (next_state == STORE) o_mem_wdata <= i_wdata;
      end
      if (state == LOAD)   o_rdata     <= load_ext;
      if (state == RMW_RD) o_mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// checked against a byte-array reference model of memory.
module tb_mem_access_unit;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          i_reset, i_valid, i_write, i_unsigned;
  logic [1:0]    i_size;
  logic [31:0]   i_addr, i_wdata;
  logic          o_stall, o_done, o_misaligned;
  logic [31:0]   o_rdata;
  logic          o_mem_enable, o_mem_read, o_mem_write;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] dmem [0:(1<<AW)-1];
  logic [7:0]  ref_bytes [0:(4<<AW)-1];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_load = '0;

  mem_access_unit #(.NB_DATA(32), .NB_ADDR(32), .ADDRWIDTH(AW)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_write(i_write),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_misaligned(o_misaligned),
    .o_mem_enable(o_mem_enable), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem: updates on the falling edge.
  always @(negedge clk) begin
    if (o_mem_enable) begin
      if (o_mem_write) begin
        dmem[o_mem_addr] = o_mem_wdata;
        last_wdata = o_mem_wdata;
        wr_cnt = wr_cnt + 1;
      end
      if (o_mem_read) begin
        mem_rdata = dmem[o_mem_addr];
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a[AW+1:0] + i]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b = int'(a[AW+1:2]) * 4;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d = wd;
    for (int i = 0; i < nbytes(sz); i++) begin
      ref_bytes[a[AW+1:0] + i] = d[7:0];
      d = d >> 8;
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int stalls,
                        output logic en_any);
    bit done = 0;
    i_write = w; i_size = sz; i_unsigned = u; i_addr = a; i_wdata = wd; i_valid = 1'b1;
    stalls = 0; en_any = 1'b0; mis = 1'b0; rd = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      en_any = en_any | o_mem_enable;
      if (o_done) begin
        done = 1;
        mis = o_misaligned;
        rd = o_rdata;
      end else if (o_stall) begin
        stalls++;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic run(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit          mis = ref_mis(sz, a);
    int          rd0 = rd_cnt;
    int          wr0 = wr_cnt;
    int          exp_lat, stalls;
    logic [31:0] exp_rd;
    logic        got_mis, en_any;
    exp_lat = mis ? 0 : (w && sz != 2'd2) ? 3 : 2;
    exp_rd  = ref_load(a, sz, u);
    do_req(w, sz, u, a, wd, rd, got_mis, stalls, en_any);
    check("misaligned", 32'(got_mis), 32'(mis));
    check("latency", stalls, exp_lat);
    check("bus_reads", rd_cnt - rd0, (mis || (w && sz == 2'd2)) ? 0 : 1);
    check("bus_writes", wr_cnt - wr0, (mis || !w) ? 0 : 1);
    if (mis) begin
      check("mis_enable", 32'({en_any, o_mem_enable}), 32'd0);
    end else if (!w) begin
      check("load_data", rd, exp_rd);
      last_load = exp_rd;
    end else begin
      ref_store(a, sz, wd);
      check("mem_word", dmem[a[AW+1:2]], ref_word(a));
      check("rdata_hold", o_rdata, last_load);
    end
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < (1 << AW); i++) begin
      dmem[i] = i;
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = 8'((i >> (8 * k)) & 'hFF);
    end
    mem_rdata = '0;
    i_reset = 1'b1; i_valid = 1'b0; i_write = 1'b0; i_size = '0; i_unsigned = 1'b0;
    i_addr = '0; i_wdata = '0;
    #1;
    check("reset_ctrl", 32'({o_stall, o_done, o_misaligned, o_mem_enable, o_mem_read, o_mem_write}), 32'd0);
    check("reset_rdata", o_rdata, 32'd0);
    check("reset_addr", 32'(o_mem_addr), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 i_reset = 1'b0;

    run(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r);  check("lw_14", r, 32'h00000005);
    run(1'b1, 2'd0, 1'b0, 32'h15, 32'hFFFFFFAB, r);
    check("sb_wdata", last_wdata, 32'h0000AB05);
    run(1'b0, 2'd0, 1'b1, 32'h15, 32'h0, r);  check("lbu_15", r, 32'h000000AB);
    run(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, r);  check("lb_15", r, 32'hFFFFFFAB);
    run(1'b1, 2'd1, 1'b0, 32'h1A, 32'h00008001, r);
    check("sh_word6", dmem[6], 32'h80010006);
    run(1'b0, 2'd1, 1'b0, 32'h1A, 32'h0, r);  check("lh_1a", r, 32'hFFFF8001);
    run(1'b0, 2'd1, 1'b1, 32'h1A, 32'h0, r);  check("lhu_1a", r, 32'h00008001);
    run(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, r);
    run(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, r);
    run(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, r);
    check("mis_mem8", dmem[8], 32'h8);
    run(1'b1, 2'd2, 1'b0, 32'h08, 32'h12345678, r);
    run(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r);  check("b2b_lw", r, 32'h12345678);

    // Reset during the write phase of a read-modify-write.
    i_write = 1'b1; i_size = 2'd0; i_unsigned = 1'b0; i_addr = 32'h04; i_wdata = 32'h000000EE;
    i_valid = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 check("rmw_wr_active", 32'(o_mem_write), 32'd1);
    i_reset = 1'b1;
    #1;
    check("rst_ctrl", 32'({o_stall, o_done, o_misaligned, o_mem_enable, o_mem_read, o_mem_write}), 32'd0);
    check("rst_bus", o_mem_wdata | 32'(o_mem_addr) | o_rdata, 32'd0);
    @(posedge clk);
    #1 check("rst_word1", dmem[1], 32'h00000001);
    i_reset = 1'b0;
    last_load = '0;
    run(1'b1, 2'd0, 1'b0, 32'h04, 32'h000000EE, r);
    check("rst_redo_word1", dmem[1], 32'h000000EE);

    for (int t = 0; t < 60; t++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic        w  = 1'($urandom_range(0, 1));
      logic        u  = 1'($urandom_range(0, 1));
      logic [31:0] a  = 32'($urandom_range(0, 255));
      logic [31:0] wd = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run(w, sz, u, a, wd, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
